// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-port AXI subordinate serving single-beat reads/writes from a local RAM
package axi_mem_responder_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W = 4;
  localparam int STRB_W = DATA_W / 8;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
  } axi_aw_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
  } axi_ar_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } axi_w_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;
endpackage

module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int              MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic    clk,
  input  logic    rst,
  input  axi_aw_t i_axi_s_aw,
  output logic    o_axi_s_awready,
  input  logic    i_axi_s_awvalid,
  input  axi_w_t  i_axi_s_w,
  output logic    o_axi_s_wready,
  input  logic    i_axi_s_wvalid,
  output axi_b_t  o_axi_s_b,
  input  logic    i_axi_s_bready,
  output logic    o_axi_s_bvalid,
  input  axi_ar_t i_axi_s_ar,
  output logic    o_axi_s_arready,
  input  logic    i_axi_s_arvalid,
  output axi_r_t  o_axi_s_r,
  input  logic    i_axi_s_rready,
  output logic    o_axi_s_rvalid
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int LB = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(MEM_DEPTH * STRB_W);
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_RESP} state_t;
  typedef enum logic {PRIO_WRITE, PRIO_READ} prio_t;
  state_t state_q, state_d;
  prio_t prio_q, prio_d;
  logic [ID_W-1:0] aw_id_q, aw_id_d, r_id_q, r_id_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0] r_resp_q, r_resp_d;
  axi_b_t b_q, b_d;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_off, rd_off;
  logic [IW-1:0] wr_idx, rd_idx;
  logic wr_ok, rd_ok, aw_hs, ar_hs, w_hs, idle;
  logic unused_ok;
  assign unused_ok = ^{i_axi_s_aw.len, i_axi_s_aw.burst, i_axi_s_ar.len, i_axi_s_ar.burst, i_axi_s_w.last};
  // Unsigned subtraction makes addresses below BASE_ADDR wrap to a huge offset, hence DECERR.
  assign wr_off = aw_addr_q - BASE_ADDR;
  assign rd_off = i_axi_s_ar.addr - BASE_ADDR;
  assign wr_ok = wr_off < SPAN;
  assign rd_ok = rd_off < SPAN;
  assign wr_idx = wr_off[IW+LB-1:LB];
  assign rd_idx = rd_off[IW+LB-1:LB];
  // Readies are gated by rst so nothing handshakes while reset is held.
  assign idle = ~rst & (state_q == IDLE);
  assign o_axi_s_awready = idle & i_axi_s_awvalid & (~i_axi_s_arvalid | prio_q == PRIO_WRITE);
  assign o_axi_s_arready = idle & i_axi_s_arvalid & (~i_axi_s_awvalid | prio_q == PRIO_READ);
  assign o_axi_s_wready = ~rst & (state_q == WR_DATA);
  assign o_axi_s_bvalid = state_q == WR_RESP;
  assign o_axi_s_rvalid = state_q == RD_RESP;
  assign o_axi_s_b = b_q;
  assign o_axi_s_r = '{id: r_id_q, data: r_data_q, resp: r_resp_q, last: 1'b1};
  assign aw_hs = o_axi_s_awready;
  assign ar_hs = o_axi_s_arready;
  assign w_hs = o_axi_s_wready & i_axi_s_wvalid;
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    aw_id_d = aw_id_q;
    aw_addr_d = aw_addr_q;
    r_id_d = r_id_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    b_d = b_q;
    if (aw_hs) begin
      aw_id_d = i_axi_s_aw.id;
      aw_addr_d = i_axi_s_aw.addr;
      state_d = WR_DATA;
      prio_d = PRIO_READ;
    end else if (ar_hs) begin
      r_id_d = i_axi_s_ar.id;
      r_data_d = rd_ok ? mem[rd_idx] : '0;
      r_resp_d = rd_ok ? 2'b00 : 2'b11;
      state_d = RD_RESP;
      prio_d = PRIO_WRITE;
    end
    if (w_hs) begin
      b_d = '{id: aw_id_q, resp: wr_ok ? 2'b00 : 2'b11};
      state_d = WR_RESP;
    end
    if ((state_q == WR_RESP && i_axi_s_bready) || (state_q == RD_RESP && i_axi_s_rready)) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q <= PRIO_WRITE;
      aw_id_q <= '0;
      aw_addr_q <= '0;
      r_id_q <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      aw_id_q <= aw_id_d;
      aw_addr_q <= aw_addr_d;
      r_id_q <= r_id_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      b_q <= b_d;
    end
  end
  always_ff @(posedge clk) begin
    if (w_hs && wr_ok)
      for (int i = 0; i < STRB_W; i++)
        if (i_axi_s_w.strb[i]) mem[wr_idx][8*i +: 8] <= i_axi_s_w.data[8*i +: 8];
  end
endmodule
